parity_check_stream: RTL

- Streaming parity checker: the receive-side counterpart of the team's parity tree generator.
- Accepts WIDTH-bit data words, each carrying one parity bit, over a valid/ready handshake.
- Recomputes parity through a 2-stage registered reduction tree and forwards each word downstream with a per-word error flag.
- Keeps a saturating error counter and a sticky error flag for status readout.

---
 rtl/parity_check_stream.sv | 92 +++++++++
 1 files changed

// File: rtl/parity_check_stream.sv
// Streaming parity checker: 2-stage registered reduction, per-word error flag,
// saturating error counter and sticky error status.
module parity_check_stream #(
  parameter int BIT_WIDTH  = 6,
  parameter int WIDTH      = 2**BIT_WIDTH,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_par,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 err_sticky
);

  localparam int NSL = WIDTH / 8;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_par;
  logic [NSL-1:0]   s1_part;
  logic             s2_valid;
  logic             s1_en;
  logic             s2_en;
  logic             fire_err;
  logic [NSL-1:0]   part;

  // First level of the tree: one parity bit per byte slice.
  always_comb begin
    part = '0;
    for (int i = 0; i < NSL; i++) begin
      part[i] = ^in_data[i*8 +: 8];
    end
  end

  assign s2_en     = !s2_valid | out_ready;
  assign s1_en     = !s1_valid | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;
  assign fire_err  = s2_valid & out_ready & out_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_par   <= 1'b0;
      s1_part  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_par   <= in_par;
      s1_part  <= part;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      out_data <= s1_data;
      out_err  <= (^s1_part) ^ s1_par ^ ODD_PARITY;
    end
  end

  // Clear wins over a same-cycle errored handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_stats) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (fire_err) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
